// File: rtl/scp_exec_ctrl_pkg.sv
// Shared definitions for the processor execution sequencer: state codes and default widths.
package scp_exec_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RST   = 2'b00,
    S_PAUSE = 2'b01,
    S_RUN   = 2'b10,
    S_HALT  = 2'b11
  } scp_state_e;

  localparam int PC_W_DEF = 8;

endpackage

// File: rtl/scp_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, one-cycle rising-edge pulse.
module scp_btn_debounce #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level;

  // A level change is accepted once the synchronized input has disagreed
  // with the accepted level for DEB_CYCLES consecutive samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], button};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync[1];
        press <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/scp_exec_ctrl.sv
// Execution sequencer: core clock enable and reset, free-run / single-step, PC breakpoint, halt.
module scp_exec_ctrl
  import scp_exec_ctrl_pkg::*;
#(
  parameter int RUN_DIV    = 25_000_000,
  parameter int DEB_CYCLES = 500_000,
  parameter int RST_CYCLES = 4,
  parameter int PC_W       = PC_W_DEF,
  parameter int CNT_W      = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic             run_sw,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic             halt_req,
  output logic             core_en,
  output logic             core_rst,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int PW = $clog2(RUN_DIV);
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  scp_state_e    cur, nxt;
  logic [PW-1:0] presc;
  logic [RW-1:0] rst_cnt;
  logic          press, run_q, en_d;
  logic          trap, run_rise;
  logic          issue, bp_set, bp_clr;

  scp_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .press  (press)
  );

  // pc is only meaningful right after an executed instruction, so resuming
  // from a breakpoint address never re-traps on it.
  assign trap     = en_d && bp_en && (pc == bp_addr);
  assign run_rise = run_sw && !run_q;
  assign state    = cur;

  always_ff @(posedge clk) begin
    if (rst) cur <= S_RST;
    else     cur <= nxt;
  end

  // Halt outranks breakpoint, which outranks the run switch and the button.
  always_comb begin
    nxt = cur;
    unique case (cur)
      S_RST:   if (rst_cnt == RW'(RST_CYCLES - 1)) nxt = run_sw ? S_RUN : S_PAUSE;
      S_PAUSE: if (halt_req) nxt = S_HALT;
               else if (!trap && run_rise) nxt = S_RUN;
      S_RUN:   if (halt_req) nxt = S_HALT;
               else if (trap || !run_sw) nxt = S_PAUSE;
      S_HALT:  if (press && !run_sw) nxt = S_RST;
      default: nxt = S_RST;
    endcase
  end

  always_comb begin
    issue  = 1'b0;
    bp_set = 1'b0;
    bp_clr = 1'b0;
    unique case (cur)
      S_PAUSE: begin
        issue  = press && (nxt == S_PAUSE);
        bp_set = trap && !halt_req;
        bp_clr = halt_req || (nxt == S_RUN);
      end
      S_RUN: begin
        issue  = (nxt == S_RUN) && (presc == PW'(RUN_DIV - 2));
        bp_set = trap && !halt_req;
        bp_clr = halt_req;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      core_en   <= 1'b0;
      core_rst  <= 1'b1;
      bp_hit    <= 1'b0;
      instr_cnt <= '0;
      presc     <= '0;
      rst_cnt   <= '0;
      run_q     <= 1'b0;
      en_d      <= 1'b0;
    end else begin
      core_en  <= issue;
      en_d     <= core_en;
      run_q    <= run_sw;
      core_rst <= (nxt == S_RST);
      // Leaving RUN for any reason discards the partial prescaler count.
      if (cur == S_RUN && nxt == S_RUN)
        presc <= (presc == PW'(RUN_DIV - 1)) ? '0 : presc + 1'b1;
      else
        presc <= '0;
      rst_cnt <= (cur == S_RST && nxt == S_RST) ? rst_cnt + 1'b1 : '0;
      if (bp_set)      bp_hit <= 1'b1;
      else if (bp_clr) bp_hit <= 1'b0;
      instr_cnt <= (nxt == S_RST) ? '0 : instr_cnt + CNT_W'(core_en);
    end
  end

endmodule
